// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_pkg
//  Description : Shared constants for the programmable counter block.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnt_pkg;

    // Behaviour at the ends of the count range
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/prog_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_counter_if
//  Description : Control/status bundle of the programmable counter.
//                The master drives control; the slave (counter) drives status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_counter_if #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8
);

    logic             enable;
    logic             up_dn;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [DIV_W-1:0] div_val;
    logic             flags_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             unf;

    modport master (
        output enable, up_dn, clear, load, load_val, div_val, flags_clr,
        input  count, tc, ovf, unf
    );

    modport slave (
        input  enable, up_dn, clear, load, load_val, div_val, flags_clr,
        output count, tc, ovf, unf
    );

endinterface : prog_counter_if
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Clock-enable prescaler. Emits one tick per div_val+1 enabled
//                cycles; restart forces the phase back to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int DIV_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             enable,
    input  wire logic             restart,
    input  wire logic [DIV_W-1:0] div_val,
    output logic                  tick
);

    localparam logic [DIV_W-1:0] c_one = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_pre;

    // >= rather than == so a div_val lowered below the current phase
    // still produces a tick on the next enabled edge instead of running
    // all the way around the prescaler.
    assign tick = enable && (r_pre >= div_val);

    // Prescaler phase: reset on restart or tick, advance on enable, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (restart) begin
            r_pre <= '0;
        end else if (tick) begin
            r_pre <= '0;
        end else if (enable) begin
            r_pre <= r_pre + c_one;
        end
    end

endmodule : tick_divider
`default_nettype wire

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prog_counter
//  Description : Up/down counter with programmable modulus, wrap or saturate
//                at the range ends, synchronous clear/load, prescaled step and
//                terminal-count / sticky overflow / underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_counter #(
    parameter int              WIDTH    = 16,
    parameter longint unsigned MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = 0,
    parameter int              DIV_W    = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    prog_counter_if.slave bus
);

    import cnt_pkg::*;

    localparam logic [WIDTH-1:0] c_mod_max = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             w_tick;
    logic             w_restart;
    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_up_wrap;
    logic [WIDTH-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_load_lim;
    logic             w_ovf_set;
    logic             w_unf_set;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    assign w_restart = bus.clear | bus.load;

    tick_divider #(
        .DIV_W   (DIV_W)
    ) u_tick_divider (
        .clk     (clk),
        .rst     (rst),
        .enable  (bus.enable),
        .restart (w_restart),
        .div_val (bus.div_val),
        .tick    (w_tick)
    );

    // Boundary detection happens before any arithmetic, so the +1/-1 paths
    // never see a value that could roll over in WIDTH bits.
    assign w_at_max   = (r_count == c_mod_max);
    assign w_at_min   = (r_count == '0);
    assign w_load_lim = (bus.load_val > c_mod_max) ? c_mod_max : bus.load_val;

    // Value taken when a step runs off either end of the range
    generate
        if (SATURATE == CNT_SAT) begin : g_sat
            assign w_up_wrap = r_count;
            assign w_dn_wrap = r_count;
        end else begin : g_wrap
            assign w_up_wrap = '0;
            assign w_dn_wrap = c_mod_max;
        end
    endgenerate

    // A boundary event only counts when a real step happens (not clear/load)
    assign w_ovf_set = !bus.clear && !bus.load && w_tick &&  bus.up_dn && w_at_max;
    assign w_unf_set = !bus.clear && !bus.load && w_tick && !bus.up_dn && w_at_min;

    // Count register and terminal-count pulse: clear > load > step > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.clear) begin
                r_count <= '0;
            end else if (bus.load) begin
                r_count <= w_load_lim;
            end else if (w_tick) begin
                if (bus.up_dn) begin
                    if (w_at_max) begin
                        r_count <= w_up_wrap;
                        r_tc    <= 1'b1;
                    end else begin
                        r_count <= r_count + c_one;
                    end
                end else begin
                    if (w_at_min) begin
                        r_count <= w_dn_wrap;
                        r_tc    <= 1'b1;
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
            end
        end
    end

    // Sticky flags: a new event wins over a coincident flags_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~bus.flags_clr);
            r_unf <= w_unf_set | (r_unf & ~bus.flags_clr);
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;

endmodule : prog_counter
`default_nettype wire

// File: doc/prog_counter.md
# prog_counter

Parametrised up/down counter with programmable modulus, wrap or saturate mode, synchronous load/clear, built-in clock-enable prescaler and terminal-count/overflow flags. Generic event and timing counter for the 16-bit MIPS datapath and peripherals (cycle counters, timers, loop/instruction counters). Replaces the fixed 4-bit enable-only counter.

## Interface
- WIDTH, 16, count width in bits (≥2)
- MOD_MAX, 2**WIDTH-1, highest count value; range is 0..MOD_MAX
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends
- DIV_W, 8, prescaler width in bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  count enable; gates the prescaler
- up_dn  in  1  1 = count up, 0 = count down
- clear  in  1  synchronous clear of count and prescaler
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value to load
- div_val  in  DIV_W  prescale: one count step per div_val+1 enabled cycles
- flags_clr  in  1  clears ovf and unf
- count  out  WIDTH  current count
- tc  out  1  one-cycle terminal-count pulse
- ovf  out  1  sticky: up step attempted at MOD_MAX
- unf  out  1  sticky: down step attempted at 0

## Operation
- Priority per cycle: clear > load > step > hold.
- clear: count←0, prescaler←0; no flag change; tc←0.
- load: count←min(load_val, MOD_MAX), prescaler←0; tc←0.
- Prescaler pre (DIV_W bits): tick = enable && (pre ≥ div_val). On tick, pre←0; else if enable, pre←pre+1; else hold. div_val=0 gives a tick every enabled cycle.
- Step on tick, up_dn=1: count<MOD_MAX → count+1; count==MOD_MAX → 0 (SATURATE=0) or hold (SATURATE=1); ovf←1, tc←1.
- Step on tick, up_dn=0: count>0 → count−1; count==0 → MOD_MAX (SATURATE=0) or hold (SATURATE=1); unf←1, tc←1.
- tc is 0 in every cycle not following a boundary step.
- flags_clr clears ovf/unf; a set event in the same cycle wins (flag stays 1).
- up_dn changes take effect on the next tick; there are no direction-change side effects.
- Arithmetic is unsigned, computed in WIDTH bits. The boundary compare precedes the increment/decrement, so there is no modular overflow except by the defined wrap.

## Timing
- Reset (async assert, sync-safe deassert assumed upstream): count=0, pre=0, tc=0, ovf=0, unf=0.
- All outputs are registered.
- count, tc and flags update on the same rising edge as the tick; there is no added latency.
- With div_val=N, the first step occurs on the (N+1)th enabled edge after reset/clear/load.
- Lowering div_val below the current pre causes an immediate tick on the next enabled edge (≥ compare).
- enable low freezes pre and count. clear/load act regardless of enable.
- rst mid-operation discards all state, including sticky flags.

## Structure
- Shared package cnt_pkg: mode constant names CNT_WRAP=0, CNT_SAT=1; no typedefs required.
- Sub-module tick_divider (params DIV_W; ports clk, rst, enable, restart, div_val, tick) holds the prescaler. restart = clear | load.
- Top prog_counter: priority mux, boundary compare, flag registers.

## Test plan
- Reset/basic: WIDTH=4, MOD_MAX=15, div_val=0, enable=1, up for 17 cycles → count 0..15, 0, 1. tc high exactly on the cycle count returns to 0; ovf=1.
- Modulus/saturate: MOD_MAX=9, SATURATE=1, load 7, up for 5 ticks → 8, 9, 9, 9, 9. tc pulses once per boundary tick (3 pulses); down from 0 holds at 0 and sets unf.
- Prescaler: div_val=3 → count steps every 4th enabled cycle. enable low for 5 cycles mid-period → pre and count frozen, then resume with the remaining phase.
- Priority: clear, load=1 with load_val=5 and a tick all in the same cycle → count=0. load alone with load_val=20 and MOD_MAX=9 → count=9.
- Flags: flags_clr coincident with an overflow step → ovf stays 1. flags_clr alone next cycle → ovf=0.
- Async reset: assert rst between clock edges mid-count → all outputs 0 immediately. Release → counting restarts from 0 with pre=0.
